// File: rtl/ll_keypad_sync.sv
// Keypad front end: 2-flop synchroniser, priority encoder, debounce FSM and one-cycle press strobe.
// Define LL_KEY_AUTOREPEAT_EN to add auto-repeat strobes while a key stays held.
module ll_keypad_sync #(
  parameter int NKEYS        = 20,
  parameter int DEBOUNCE     = 2,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic [NKEYS-1:0] in,
  output logic [4:0]       keycode,
  output logic             strobe,
  output logic             keydown,
  output logic             multi
);

  localparam int CNT_W = ($clog2(DEBOUNCE + 1) > 2) ? $clog2(DEBOUNCE + 1) : 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [NKEYS-1:0] r_s1, r_s;
  state_t           r_state, w_state_nxt;
  logic [4:0]       r_cand, w_cand_nxt, w_keycode_nxt, w_code;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_keydown_nxt, w_strobe_nxt, w_strobe_d, w_any;

  // Priority encoder: ascending scan so the highest set bit wins.
  always_comb begin
    w_code = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (r_s[i]) w_code = 5'(i);
    end
  end

  assign w_any = |r_s;
  assign multi = |(r_s & (r_s - NKEYS'(1)));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_keycode_nxt = keycode;
    w_keydown_nxt = keydown;
    w_strobe_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_DEBOUNCE;
          w_cand_nxt  = w_code;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (!w_any) begin
          w_state_nxt = keydown ? S_RELEASE : S_IDLE;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_code != r_cand) begin
          w_cand_nxt = w_code;
          w_cnt_nxt  = CNT_W'(1);
        end else if (r_cnt == CNT_W'(DEBOUNCE)) begin
          w_state_nxt   = S_PRESSED;
          w_keycode_nxt = r_cand;
          w_keydown_nxt = 1'b1;
          w_strobe_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!w_any) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = CNT_W'(1);
        end else if (w_code != keycode) begin
          w_state_nxt = S_DEBOUNCE;
          w_cand_nxt  = w_code;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (w_any && (w_code == keycode)) begin
          // Brief dropout of the same key: resume without a new event.
          w_state_nxt = S_PRESSED;
        end else if (w_any) begin
          w_state_nxt = S_DEBOUNCE;
          w_cand_nxt  = w_code;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_cnt == CNT_W'(DEBOUNCE)) begin
          w_state_nxt   = S_IDLE;
          w_keydown_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef LL_KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] r_rpt, w_rpt_nxt, w_rpt_inc;
  logic             r_rpt_again, w_rpt_again_nxt, w_rpt_fire, w_enter, w_hold;

  assign w_enter   = (w_state_nxt == S_PRESSED) && (r_state != S_PRESSED);
  assign w_hold    = (r_state == S_PRESSED) && (w_state_nxt == S_PRESSED);
  assign w_rpt_inc = r_rpt + RPT_W'(1);

  // First repeat waits REPEAT_DELAY; later ones every REPEAT_RATE.
  always_comb begin
    w_rpt_nxt       = r_rpt;
    w_rpt_again_nxt = r_rpt_again;
    w_rpt_fire      = 1'b0;
    if (w_enter) begin
      w_rpt_nxt       = '0;
      w_rpt_again_nxt = 1'b0;
    end else if (w_hold) begin
      if (w_rpt_inc == (r_rpt_again ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY))) begin
        w_rpt_fire      = 1'b1;
        w_rpt_nxt       = '0;
        w_rpt_again_nxt = 1'b1;
      end else begin
        w_rpt_nxt = w_rpt_inc;
      end
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_rpt       <= '0;
      r_rpt_again <= 1'b0;
    end else begin
      r_rpt       <= w_rpt_nxt;
      r_rpt_again <= w_rpt_again_nxt;
    end
  end

  assign w_strobe_d = w_strobe_nxt | w_rpt_fire;
`else
  assign w_strobe_d = w_strobe_nxt;
`endif

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_s1    <= '0;
      r_s     <= '0;
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      keycode <= '0;
      keydown <= 1'b0;
      strobe  <= 1'b0;
    end else begin
      r_s1    <= in;
      r_s     <= r_s1;
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      keycode <= w_keycode_nxt;
      keydown <= w_keydown_nxt;
      strobe  <= w_strobe_d;
    end
  end

endmodule

// File: tb/tb_ll_keypad_sync.sv
// Self-checking bench for ll_keypad_sync: directed scenarios plus random key traffic against a reference model.
module tb_ll_keypad_sync;

  localparam int DEB   = 2;
  localparam int DELAY = 50;
  localparam int RATE  = 10;

  logic        hz100 = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] in    = '0;
  logic [4:0]  keycode;
  logic        strobe, keydown, multi;

  int n_checks = 0;
  int n_errors = 0;

  ll_keypad_sync dut (
    .hz100  (hz100),
    .reset  (reset),
    .in     (in),
    .keycode(keycode),
    .strobe (strobe),
    .keydown(keydown),
    .multi  (multi)
  );

  always #5 hz100 = ~hz100;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: spec rules applied once per clock edge on plain integers.
  logic [19:0] m_s1, m_s;
  string       m_mode;
  int          m_cand, m_cnt, m_keycode, m_rpt_age;
  bit          m_keydown, m_strobe, m_rpt_again;

  function automatic int top_key(input logic [19:0] s);
    for (int i = 19; i >= 0; i--) if (s[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_mode = "IDLE";
    m_cand = 0; m_cnt = 0; m_keycode = 0; m_keydown = 0; m_strobe = 0;
    m_rpt_age = 0; m_rpt_again = 0;
  endtask

  task automatic model_step(input logic [19:0] v);
    bit    any   = |m_s;
    int    code  = top_key(m_s);
    bit    fire  = 0;
    bit    enter = 0;
    string was   = m_mode;
    if (m_mode == "IDLE") begin
      if (any) begin m_mode = "DEBOUNCE"; m_cand = code; m_cnt = 1; end
    end else if (m_mode == "DEBOUNCE") begin
      if (!any) begin m_mode = m_keydown ? "RELEASE" : "IDLE"; m_cnt = 1; end
      else if (code != m_cand) begin m_cand = code; m_cnt = 1; end
      else if (m_cnt == DEB) begin
        m_mode = "PRESSED"; m_keycode = m_cand; m_keydown = 1; fire = 1; enter = 1;
      end else m_cnt++;
    end else if (m_mode == "PRESSED") begin
      if (!any) begin m_mode = "RELEASE"; m_cnt = 1; end
      else if (code != m_keycode) begin m_mode = "DEBOUNCE"; m_cand = code; m_cnt = 1; end
    end else begin
      if (any && code == m_keycode) begin m_mode = "PRESSED"; enter = 1; end
      else if (any) begin m_mode = "DEBOUNCE"; m_cand = code; m_cnt = 1; end
      else if (m_cnt == DEB) begin m_mode = "IDLE"; m_keydown = 0; end
      else m_cnt++;
    end
`ifdef LL_KEY_AUTOREPEAT_EN
    if (enter) begin
      m_rpt_age = 0; m_rpt_again = 0;
    end else if (was == "PRESSED" && m_mode == "PRESSED") begin
      m_rpt_age++;
      if (m_rpt_age == (m_rpt_again ? RATE : DELAY)) begin
        fire = 1; m_rpt_age = 0; m_rpt_again = 1;
      end
    end
`endif
    m_strobe = fire;
    m_s  = m_s1;
    m_s1 = v;
  endtask

  // Per-window observations of the DUT for directed scenarios.
  int cyc_idx, strobe_cnt, first_strobe;
  int strobe_at[$];
  bit multi_seen, keydown_low_seen;

  task automatic clear_window();
    cyc_idx = 0; strobe_cnt = 0; first_strobe = -1;
    strobe_at.delete(); multi_seen = 0; keydown_low_seen = 0;
  endtask

  task automatic cycle(input logic [19:0] v, input logic rst_v);
    in    = v;
    reset = rst_v;
    @(posedge hz100);
    if (!reset) model_reset();
    else model_step(v);
    @(negedge hz100);
    check("keycode", 32'(keycode), 32'(m_keycode));
    check("strobe", 32'(strobe), 32'(m_strobe));
    check("keydown", 32'(keydown), 32'(m_keydown));
    check("multi", 32'(multi), 32'($countones(m_s) > 1));
    if (strobe) begin
      if (first_strobe < 0) first_strobe = cyc_idx;
      strobe_cnt++;
      strobe_at.push_back(cyc_idx);
    end
    if (multi) multi_seen = 1;
    if (!keydown) keydown_low_seen = 1;
    cyc_idx++;
  endtask

  task automatic hold(input logic [19:0] v, input int n);
    for (int k = 0; k < n; k++) cycle(v, 1'b1);
  endtask

  function automatic logic [19:0] key(input int k);
    logic [19:0] v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  initial begin
    int exp_at[$];
    model_reset();

    // 1: held key during reset gives nothing; after release, one strobe after edge 4.
    for (int k = 0; k < 3; k++) cycle(key(5), 1'b0);
    check("t1_rst_keycode", 32'(keycode), 0);
    check("t1_rst_strobe", 32'(strobe), 0);
    check("t1_rst_keydown", 32'(keydown), 0);
    clear_window();
    hold(key(5), 10);
    check("t1_first", first_strobe, 4);
    check("t1_count", strobe_cnt, 1);
    check("t1_keycode", 32'(keycode), 5);
    check("t1_keydown", 32'(keydown), 1);
    hold('0, 10);

    // 2: single-cycle glitch is rejected.
    clear_window();
    hold(key(18), 1);
    hold('0, 6);
    check("t2_count", strobe_cnt, 0);
    check("t2_keydown", 32'(keydown), 0);
    check("t2_keycode", 32'(keycode), 5);

    // 3: chatter then stable hold gives exactly one strobe; release clears keydown.
    clear_window();
    for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? key(0) : 20'd0, 1);
    hold(key(0), 20);
    check("t3_count", strobe_cnt, 1);
    check("t3_keycode", 32'(keycode), 0);
    hold('0, 5);
    check("t3_release", 32'(keydown), 0);
    hold('0, 5);

    // 4: higher key overrides, dropping it returns to the lower key.
    clear_window();
    hold(key(3), 10);
    check("t4_first", strobe_cnt, 1);
    hold(key(3) | key(17), 10);
    check("t4_multi", 32'(multi_seen), 1);
    check("t4_second", strobe_cnt, 2);
    check("t4_code17", 32'(keycode), 17);
    hold(key(3), 10);
    check("t4_third", strobe_cnt, 3);
    check("t4_code3", 32'(keycode), 3);
    hold('0, 10);

    // 5: one-cycle gap in a long hold is not a new press.
    hold(key(9), 100);
    clear_window();
    hold('0, 1);
    hold(key(9), 20);
    check("t5_count", strobe_cnt, 0);
    check("t5_keydown_low", 32'(keydown_low_seen), 0);
    hold('0, 10);

    // 6: long hold; repeat strobes only with auto-repeat built in.
    clear_window();
    hold(key(19), 100);
    exp_at = '{4};
`ifdef LL_KEY_AUTOREPEAT_EN
    exp_at = '{4, 54, 64, 74, 84, 94};
`endif
    check("t6_count", strobe_at.size(), exp_at.size());
    for (int k = 0; k < exp_at.size() && k < strobe_at.size(); k++)
      check("t6_edge", strobe_at[k], exp_at[k]);
    check("t6_keycode", 32'(keycode), 19);
    hold('0, 10);

    // Reset mid-operation drops strobe at once; held key is then a fresh press.
    clear_window();
    hold(key(12), 5);
    check("rst_pre_strobe", 32'(strobe), 1);
    #1 reset = 1'b0;
    #1;
    check("rst_strobe", 32'(strobe), 0);
    check("rst_keydown", 32'(keydown), 0);
    check("rst_keycode", 32'(keycode), 0);
    model_reset();
    for (int k = 0; k < 3; k++) cycle(key(12), 1'b0);
    clear_window();
    hold(key(12), 8);
    check("rst_fresh_first", first_strobe, 4);
    check("rst_fresh_count", strobe_cnt, 1);
    hold('0, 10);

    // Random traffic: idle gaps, single keys, key pairs, short pulses, occasional reset.
    for (int seg = 0; seg < 250; seg++) begin
      int          sel = $urandom_range(0, 9);
      int          len = $urandom_range(1, 12);
      logic [19:0] v   = '0;
      if (sel >= 3 && sel <= 6) v = key($urandom_range(0, 19));
      else if (sel >= 7 && sel <= 8) v = key($urandom_range(0, 19)) | key($urandom_range(0, 19));
      if (sel == 9) for (int k = 0; k < 2; k++) cycle(key($urandom_range(0, 19)), 1'b0);
      else hold(v, len);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
